// File: rtl/dds_pkg.sv
// Shared defaults and the FSM state type for the DDS frequency-sweep controller.
// S_DOWN exists only when SWEEP_BIDIR_EN is defined.
package dds_pkg;

    localparam int PW_DEFAULT = 8;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
`ifdef SWEEP_BIDIR_EN
        S_DOWN   = 3'd3,
`endif
        S_FINISH = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep request/configuration and accumulator-side outputs of dds_sweep_ctrl.
// The master drives requests and config; the slave (the controller) drives phinc and status.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int DW = DW_DEFAULT
) ();
    logic          start;
    logic          abort;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_stop;
    logic [PW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [PW-1:0] phinc;
    logic          acc_clrn;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, f_start, f_stop, f_step, dwell,
        input  phinc, acc_clrn, busy, done
    );

    modport slave (
        input  start, abort, f_start, f_stop, f_step, dwell,
        output phinc, acc_clrn, busy, done
    );
endinterface

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter timing how long each phase increment is held.
// tc is high while the count sits at zero; the counter parks there until reloaded.
module sweep_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          tc
);
    logic [DW-1:0] count;

    always_ff @(posedge clk) begin
        if (clr || flush)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - DW'(1);
    end

    assign tc = (count == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency-sweep controller feeding a DDS phase accumulator's increment.
// Define SWEEP_BIDIR_EN to sweep back down from f_stop to f_start before finishing.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    dds_sweep_ctrl_if.slave sif
);
    sweep_state_t  state;
    logic [PW-1:0] start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q, reload;
    logic [PW:0]   up_sum;
    logic [PW-1:0] up_next;
    logic          at_top, active, tc, tmr_load, tmr_flush;
`ifdef SWEEP_BIDIR_EN
    logic [PW-1:0] dn_next;
    logic          at_bottom, goes_down;
`endif

    // Step arithmetic is one bit wider so increments saturate at f_stop instead of wrapping.
    always_comb begin
        reload  = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
        up_sum  = {1'b0, sif.phinc} + {1'b0, step_q};
        up_next = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[PW-1:0];
        at_top  = (sif.phinc >= stop_q) || (step_q == '0);
`ifdef SWEEP_BIDIR_EN
        goes_down = (stop_q > start_q) && (step_q != '0);
        at_bottom = (sif.phinc <= start_q);
        dn_next   = ((sif.phinc - start_q) > step_q) ? sif.phinc - step_q : start_q;
        active    = (state == S_ARM) || (state == S_RUN) || (state == S_DOWN);
        tmr_load  = (state == S_ARM)
                 || ((state == S_RUN) && tc && (!at_top || goes_down))
                 || ((state == S_DOWN) && tc && !at_bottom);
`else
        active    = (state == S_ARM) || (state == S_RUN);
        tmr_load  = (state == S_ARM) || ((state == S_RUN) && tc && !at_top);
`endif
        tmr_flush = active && sif.abort;
    end

    sweep_dwell_timer #(.DW(DW)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .flush    (tmr_flush),
        .load     (tmr_load),
        .load_val (reload),
        .tc       (tc)
    );

    // Outputs are assigned on the transition so they already hold the new state's values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= S_IDLE;
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            sif.phinc    <= '0;
            sif.acc_clrn <= 1'b0;
            sif.busy     <= 1'b0;
            sif.done     <= 1'b0;
        end else begin
            sif.done <= 1'b0;
            if (active && sif.abort) begin
                state        <= S_IDLE;
                sif.phinc    <= '0;
                sif.acc_clrn <= 1'b0;
                sif.busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sif.phinc    <= '0;
                        sif.acc_clrn <= 1'b0;
                        sif.busy     <= 1'b0;
                        if (sif.start) begin
                            start_q   <= sif.f_start;
                            stop_q    <= sif.f_stop;
                            step_q    <= sif.f_step;
                            dwell_q   <= sif.dwell;
                            sif.phinc <= sif.f_start;
                            sif.busy  <= 1'b1;
                            state     <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        sif.acc_clrn <= 1'b1;
                        state        <= S_RUN;
                    end
                    S_RUN: begin
                        if (tc) begin
                            if (!at_top) begin
                                sif.phinc <= up_next;
`ifdef SWEEP_BIDIR_EN
                            end else if (goes_down) begin
                                sif.phinc <= dn_next;
                                state     <= S_DOWN;
`endif
                            end else begin
                                sif.phinc    <= '0;
                                sif.acc_clrn <= 1'b0;
                                sif.busy     <= 1'b0;
                                sif.done     <= 1'b1;
                                state        <= S_FINISH;
                            end
                        end
                    end
`ifdef SWEEP_BIDIR_EN
                    S_DOWN: begin
                        if (tc) begin
                            if (!at_bottom) begin
                                sif.phinc <= dn_next;
                            end else begin
                                sif.phinc    <= '0;
                                sif.acc_clrn <= 1'b0;
                                sif.busy     <= 1'b0;
                                sif.done     <= 1'b1;
                                state        <= S_FINISH;
                            end
                        end
                    end
`endif
                    S_FINISH: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state        <= S_IDLE;
                        sif.phinc    <= '0;
                        sif.acc_clrn <= 1'b0;
                        sif.busy     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed sweeps plus random configurations
// compared cycle by cycle against a list-based sweep model (honours SWEEP_BIDIR_EN).
module tb_dds_sweep_ctrl;

    typedef struct packed {
        logic [7:0] ph;
        logic       clrn;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk;
    logic clr;
    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    dds_sweep_ctrl_if #(.PW(8), .DW(16)) sif ();

    dds_sweep_ctrl #(.PW(8), .DW(16)) dut (
        .clk (clk),
        .clr (clr),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(input int ph, input bit c, input bit b, input bit d);
        obs_t o;
        o.ph   = 8'(ph);
        o.clrn = c;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(int'(sif.phinc), sif.acc_clrn, sif.busy, sif.done);
    endfunction

    // Expected per-cycle trace from the ARM cycle on: list of increments, each held for the dwell.
    function automatic void model(input int fs, input int fe, input int st, input int dw);
        int vals[$];
        int v;
        int d;
        exp_q.delete();
        d = (dw == 0) ? 1 : dw;
        v = fs;
        vals.push_back(v);
        if (fe > fs && st > 0) begin
            while (v < fe) begin
                v = (v + st > fe) ? fe : v + st;
                vals.push_back(v);
            end
`ifdef SWEEP_BIDIR_EN
            while (v > fs) begin
                v = (v - st < fs) ? fs : v - st;
                vals.push_back(v);
            end
`endif
        end
        exp_q.push_back(mk(fs, 1'b0, 1'b1, 1'b0));
        foreach (vals[k])
            repeat (d) exp_q.push_back(mk(vals[k], 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1));
        repeat (3) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    endfunction

    function automatic void idle_after(input int idx);
        for (int k = idx + 1; k < exp_q.size(); k++)
            exp_q[k] = mk(0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic set_cfg(input int fs, input int fe, input int st, input int dw);
        sif.f_start = 8'(fs);
        sif.f_stop  = 8'(fe);
        sif.f_step  = 8'(st);
        sif.dwell   = 16'(dw);
    endtask

    // Pulses start, then records one sample per cycle beginning with the ARM cycle.
    task automatic run_capture(input int n, input int abort_at, input int clr_at, input int start_at);
        obs_q.delete();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            obs_q.push_back(sample());
            sif.abort = (i == abort_at);
            clr       = (i == clr_at);
            sif.start = (i == start_at);
            if (i == start_at)
                set_cfg($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(9));
            tick();
        end
        sif.abort = 1'b0;
        clr       = 1'b0;
        sif.start = 1'b0;
    endtask

    task automatic test_reset();
        sif.start = 1'b1;
        sif.abort = 1'b1;
        set_cfg(2, 8, 2, 20);
        clr = 1'b1;
        repeat (2) tick();
        checks++;
        if (sample() !== mk(0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %h want %h", sample(), mk(0, 1'b0, 1'b0, 1'b0));
        end
        clr       = 1'b0;
        sif.start = 1'b0;
        sif.abort = 1'b0;
        repeat (2) tick();
        checks++;
        if (sample() !== mk(0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got %h want %h", sample(), mk(0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_sweep();
        int busy_n = 0;
        int done_n = 0;
`ifdef SWEEP_BIDIR_EN
        int busy_want = 141;
`else
        int busy_want = 81;
`endif
        set_cfg(2, 8, 2, 20);
        model(2, 8, 2, 20);
        run_capture(exp_q.size(), -1, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL sweep[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
            busy_n += int'(obs_q[i].busy);
            done_n += int'(obs_q[i].done);
        end
        checks++;
        if (busy_n != busy_want) begin
            failures++;
            $display("[TB] FAIL sweep_busy_cycles got %0d want %0d", busy_n, busy_want);
        end
        checks++;
        if (done_n != 1) begin
            failures++;
            $display("[TB] FAIL sweep_done_pulses got %0d want 1", done_n);
        end
    endtask

    task automatic test_no_wrap();
        int done_n = 0;
        set_cfg(250, 255, 4, 3);
        model(250, 255, 4, 3);
        run_capture(exp_q.size(), -1, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL no_wrap[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
            done_n += int'(obs_q[i].done);
        end
        checks++;
        if (obs_q[7].ph !== 8'd255) begin
            failures++;
            $display("[TB] FAIL no_wrap_top got %0d want 255", obs_q[7].ph);
        end
        checks++;
        if (done_n != 1) begin
            failures++;
            $display("[TB] FAIL no_wrap_done_pulses got %0d want 1", done_n);
        end
    endtask

    task automatic test_abort();
        set_cfg(2, 8, 2, 20);
        model(2, 8, 2, 20);
        idle_after(30);
        run_capture(exp_q.size(), 30, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL abort[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clr();
        set_cfg(2, 8, 2, 20);
        model(2, 8, 2, 20);
        idle_after(10);
        run_capture(exp_q.size(), -1, 10, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL clr_mid[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_midstart();
        set_cfg(2, 8, 2, 20);
        model(2, 8, 2, 20);
        run_capture(exp_q.size(), -1, -1, 15);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL mid_start[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_dwell_zero();
        set_cfg(5, 7, 1, 0);
        model(5, 7, 1, 0);
        run_capture(exp_q.size(), -1, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL dwell_zero[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        set_cfg(5, 3, 1, 4);
        model(5, 3, 1, 4);
        run_capture(exp_q.size(), -1, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL stop_below_start[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int fs, fe, st, dw, ab;
        for (int r = 0; r < 16; r++) begin
            fs = $urandom_range(255);
            fe = $urandom_range(255);
            st = $urandom_range(12);
            dw = $urandom_range(4);
            set_cfg(fs, fe, st, dw);
            model(fs, fe, st, dw);
            ab = -1;
            if (r % 4 == 3) begin
                ab = $urandom_range(exp_q.size() - 5);
                idle_after(ab);
            end
            run_capture(exp_q.size(), ab, -1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("[TB] FAIL random%0d[%0d] cfg=%0d/%0d/%0d/%0d got %h want %h",
                             r, i, fs, fe, st, dw, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        clr       = 1'b1;
        sif.start = 1'b0;
        sif.abort = 1'b0;
        set_cfg(0, 0, 0, 0);
        test_reset();
        test_sweep();
        test_no_wrap();
        test_abort();
        test_clr();
        test_midstart();
        test_dwell_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter: PW, default 8, phase-increment width (matches the phase accumulator's phinc).
REQ-002 Parameter: DW, default 16, dwell-counter width.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, port clr.
REQ-004 Port: clk  in  1  system clock, all logic on rising edge.
REQ-005 Port: clr  in  1  synchronous active-high reset.
REQ-006 Port: start  in  1  sweep request, sampled in IDLE only.
REQ-007 Port: abort  in  1  terminate sweep, no done pulse.
REQ-008 Port: f_start  in  PW  first increment.
REQ-009 Port: f_stop  in  PW  final increment.
REQ-010 Port: f_step  in  PW  increment step.
REQ-011 Port: dwell  in  DW  cycles per increment value; 0 treated as 1.
REQ-012 Port: phinc  out  PW  registered increment to the accumulator.
REQ-013 Port: acc_clrn  out  1  registered active-low clear to the accumulator.
REQ-014 Port: busy  out  1  high from ARM through last RUN/DOWN cycle.
REQ-015 Port: done  out  1  one-cycle pulse on normal completion.

Function
REQ-016 States: IDLE, ARM, RUN, DOWN (bidirectional build only), FINISH; all outputs registered.
REQ-017 IDLE: phinc=0, acc_clrn=0, busy=0; start=1 latches f_start/f_stop/f_step/dwell and enters ARM next cycle.
REQ-018 ARM (exactly 1 cycle): phinc=f_start, acc_clrn=0, busy=1; then RUN.
REQ-019 RUN: acc_clrn=1; each phinc value held exactly max(dwell,1) cycles via a down-counter.
REQ-020 At dwell terminal count in RUN: if phinc==f_stop go to FINISH (or DOWN); else phinc = min(phinc+f_step, f_stop), computed PW+1 bits wide, never wrapping.
REQ-021 f_stop<=f_start or f_step==0: f_start held for one dwell, then FINISH.
REQ-022 FINISH (1 cycle): done=1, busy=0, acc_clrn=0, phinc=0; then IDLE.
REQ-023 abort=1 in ARM/RUN/DOWN: next cycle IDLE outputs, done stays 0; abort ignored in IDLE/FINISH.
REQ-024 start while not IDLE ignored; config inputs changing mid-sweep have no effect.
REQ-025 Simultaneous abort and dwell terminal count: abort wins.

Reset
REQ-026 clr=1 at any clock edge: state IDLE, phinc=0, acc_clrn=0, busy=0, done=0, dwell counter 0; overrides start/abort.
REQ-027 clr mid-sweep discards latched configuration; no done pulse.

Configuration
REQ-028 Macro SWEEP_BIDIR_EN defined: at f_stop terminal count enter DOWN; DOWN decrements phinc = max(phinc-f_step, f_start) per dwell; at f_start terminal count enter FINISH; f_stop and f_start dwells each occur once.
REQ-029 SWEEP_BIDIR_EN undefined: DOWN state and decrement logic absent; RUN goes directly to FINISH.

Structure
REQ-030 Package dds_pkg holds PW/DW defaults and the state enum type.
REQ-031 Sub-module sweep_dwell_timer: loadable DW-bit down-counter with terminal-count output; instantiated once.

Verification
REQ-032 f_start=2, f_stop=8, f_step=2, dwell=20 -> phinc 2,4,6,8 each 20 cycles with acc_clrn=1; done one cycle after last dwell; busy=1 for 81 cycles.
REQ-033 f_start=250, f_stop=255, f_step=4, dwell=3 -> phinc 250,254,255, no wrap to 2; done once.
REQ-034 Sweep of REQ-032, abort at RUN cycle 30 -> next cycle phinc=0, acc_clrn=0, busy=0, done never asserts.
REQ-035 clr pulsed at RUN cycle 10, and start pulsed mid-sweep in a separate run -> reset to IDLE values; mid-sweep start has no effect.
REQ-036 dwell=0, f_start=5, f_stop=7, f_step=1 -> 5,6,7 one cycle each; f_stop=3, f_start=5 -> 5 for one dwell then done.
REQ-037 SWEEP_BIDIR_EN defined, REQ-032 stimulus -> 2,4,6,8,6,4,2 each 20 cycles, then done.
